// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU core
// (C port) and the host/communication interface (H port).
// - Combinational grant with fixed CPU priority.
// - Read data returned two cycles after grant through a {valid, owner}
//   tracking stage followed by the per-port DQ/DV registers.
// - Optional host starvation guard, enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          C_REQ,
    input  logic          C_WE,
    input  logic [AW-1:0] C_A,
    input  logic [DW-1:0] C_DI,
    output logic          C_GNT,
    output logic [DW-1:0] C_DQ,
    output logic          C_DV,
    input  logic          H_REQ,
    input  logic          H_WE,
    input  logic [AW-1:0] H_A,
    input  logic [DW-1:0] H_DI,
    output logic          H_GNT,
    output logic [DW-1:0] H_DQ,
    output logic          H_DV,
    output logic          M_WE,
    output logic [AW-1:0] M_A,
    output logic [DW-1:0] M_DI,
    input  logic [DW-1:0] M_DQ
);

    logic          c_gnt;
    logic          h_gnt;
    logic          h_force;
    logic          s1_vld;
    logic          s1_own;     // 0 = CPU, 1 = host
    logic [DW-1:0] c_dq_q;
    logic [DW-1:0] h_dq_q;
    logic          c_dv_q;
    logic          h_dv_q;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;
    logic       force_q;

    // Count host wait cycles; arm a one-shot host override once the limit is hit.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wait_cnt <= 8'd0;
            force_q  <= 1'b0;
        end else if (!H_REQ || h_gnt) begin
            wait_cnt <= 8'd0;
            force_q  <= 1'b0;
        end else if (wait_cnt == MAX_WAIT_C) begin
            wait_cnt <= 8'd0;
            force_q  <= 1'b1;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign h_force = force_q;
`else
    assign h_force = 1'b0;
`endif

    // Grant: CPU wins contention unless the starvation override is armed.
    always_comb begin
        h_gnt = 1'b0;
        c_gnt = 1'b0;
        if (H_REQ && (!C_REQ || h_force)) begin
            h_gnt = 1'b1;
        end else if (C_REQ) begin
            c_gnt = 1'b1;
        end
    end

    // Memory drive: winner's qualifiers, CPU values parked when idle.
    always_comb begin
        M_WE = (c_gnt & C_WE) | (h_gnt & H_WE);
        M_A  = C_A;
        M_DI = C_DI;
        if (h_gnt) begin
            M_A  = H_A;
            M_DI = H_DI;
        end
    end

    // Track the owner of a read issued this cycle; memory data arrives next cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_vld <= 1'b0;
            s1_own <= 1'b0;
        end else begin
            s1_vld <= (c_gnt & ~C_WE) | (h_gnt & ~H_WE);
            s1_own <= h_gnt;
        end
    end

    // Capture memory read data into the owning port and pulse its DV.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            c_dq_q <= '0;
            h_dq_q <= '0;
            c_dv_q <= 1'b0;
            h_dv_q <= 1'b0;
        end else begin
            c_dv_q <= s1_vld & ~s1_own;
            h_dv_q <= s1_vld & s1_own;
            if (s1_vld && !s1_own) begin
                c_dq_q <= M_DQ;
            end
            if (s1_vld && s1_own) begin
                h_dq_q <= M_DQ;
            end
        end
    end

    assign C_GNT = c_gnt;
    assign H_GNT = h_gnt;
    assign C_DQ  = c_dq_q;
    assign H_DQ  = h_dq_q;
    assign C_DV  = c_dv_q;
    assign H_DV  = h_dv_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter with a behavioural single-port memory
// (registered read address, write at the clock edge).
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          CLK;
    logic          RSTN;
    logic          C_REQ, C_WE, H_REQ, H_WE;
    logic [AW-1:0] C_A, H_A;
    logic [DW-1:0] C_DI, H_DI;
    logic          C_GNT, H_GNT, C_DV, H_DV, M_WE;
    logic [DW-1:0] C_DQ, H_DQ, M_DI, M_DQ;
    logic [AW-1:0] M_A;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .C_REQ(C_REQ), .C_WE(C_WE), .C_A(C_A), .C_DI(C_DI),
        .C_GNT(C_GNT), .C_DQ(C_DQ), .C_DV(C_DV),
        .H_REQ(H_REQ), .H_WE(H_WE), .H_A(H_A), .H_DI(H_DI),
        .H_GNT(H_GNT), .H_DQ(H_DQ), .H_DV(H_DV),
        .M_WE(M_WE), .M_A(M_A), .M_DI(M_DI), .M_DQ(M_DQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] addr_q = '0;
    always @(posedge CLK) begin
        if (M_WE) mem[M_A] <= M_DI;
        addr_q <= M_A;
    end
    assign M_DQ = mem[addr_q];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        @(negedge CLK);
        C_REQ = 1'b0; C_WE = 1'b0;
        H_REQ = 1'b0; H_WE = 1'b0;
    endtask

    task automatic c_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        C_REQ = 1'b1; C_WE = 1'b1; C_A = a; C_DI = d;
        #1 check("c_write_gnt", {63'd0, C_GNT}, 64'd1);
    endtask

    typedef struct packed {
        logic          c_req;
        logic          c_we;
        logic [AW-1:0] c_a;
        logic [DW-1:0] c_di;
        logic          h_req;
        logic          h_we;
        logic [AW-1:0] h_a;
        logic [DW-1:0] h_di;
        logic          e_cg;
        logic          e_hg;
        logic          e_we;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_di;
    } vec_t;

    vec_t tbl [8];
    logic [DW-1:0] stream_val [6];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 16'h0011, 32'h1,        1'b0, 1'b0, 16'h0022, 32'h2,    1'b0, 1'b0, 1'b0, 16'h0011, 32'h1};
        tbl[1] = '{1'b1, 1'b0, 16'h0011, 32'h1,        1'b0, 1'b0, 16'h0022, 32'h2,    1'b1, 1'b0, 1'b0, 16'h0011, 32'h1};
        tbl[2] = '{1'b1, 1'b1, 16'h00C8, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0022, 32'h2,    1'b1, 1'b0, 1'b1, 16'h00C8, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b1, 16'h00C8, 32'h3,        1'b1, 1'b1, 16'h0064, 32'hCAFE, 1'b0, 1'b1, 1'b1, 16'h0064, 32'hCAFE};
        tbl[4] = '{1'b0, 1'b0, 16'h0033, 32'h4,        1'b1, 1'b0, 16'h0065, 32'h5,    1'b0, 1'b1, 1'b0, 16'h0065, 32'h5};
        tbl[5] = '{1'b1, 1'b0, 16'h0033, 32'h6,        1'b1, 1'b1, 16'h0066, 32'h7,    1'b1, 1'b0, 1'b0, 16'h0033, 32'h6};
        tbl[6] = '{1'b1, 1'b1, 16'h00C9, 32'h8,        1'b1, 1'b0, 16'h0067, 32'h9,    1'b1, 1'b0, 1'b1, 16'h00C9, 32'h8};
        tbl[7] = '{1'b0, 1'b1, 16'h00CA, 32'hA,        1'b0, 1'b1, 16'h0068, 32'hB,    1'b0, 1'b0, 1'b0, 16'h00CA, 32'hA};
        stream_val[0] = 32'd500;
        stream_val[1] = 32'd100000;
        stream_val[2] = 32'd1;
        stream_val[3] = 32'd5;
        stream_val[4] = 32'd2;
        stream_val[5] = 32'd10;

        RSTN = 1'b0;
        C_REQ = 1'b0; C_WE = 1'b0; C_A = '0; C_DI = '0;
        H_REQ = 1'b0; H_WE = 1'b0; H_A = '0; H_DI = '0;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        check("rst_c_dq", {32'd0, C_DQ}, 64'd0);
        check("rst_h_dq", {32'd0, H_DQ}, 64'd0);
        check("rst_dv",   {62'd0, C_DV, H_DV}, 64'd0);
        RSTN = 1'b1;

        // Combinational grant / memory mux vectors
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            C_REQ = tbl[i].c_req; C_WE = tbl[i].c_we; C_A = tbl[i].c_a; C_DI = tbl[i].c_di;
            H_REQ = tbl[i].h_req; H_WE = tbl[i].h_we; H_A = tbl[i].h_a; H_DI = tbl[i].h_di;
            #1 check($sformatf("vec%0d", i),
                     {13'd0, C_GNT, H_GNT, M_WE, M_A, M_DI},
                     {13'd0, tbl[i].e_cg, tbl[i].e_hg, tbl[i].e_we, tbl[i].e_a, tbl[i].e_di});
        end
        idle();
        idle();
        idle();

        // Preload through the CPU port: streaming values at 0..5 (MEM[3]=5)
        for (int i = 0; i < 6; i++) c_write(AW'(i), stream_val[i]);
        idle();
        idle();
        idle();

        // Single CPU read of address 3
        @(negedge CLK);
        C_REQ = 1'b1; C_WE = 1'b0; C_A = 16'd3;
        #1 check("rd_c_gnt", {62'd0, C_GNT, H_GNT}, 64'b10);
        idle();
        check("rd_dv_n1", {62'd0, C_DV, H_DV}, 64'd0);
        @(negedge CLK);
        check("rd_dv_n2", {62'd0, C_DV, H_DV}, 64'b10);
        check("rd_c_dq",  {32'd0, C_DQ}, 64'd5);
        @(negedge CLK);
        check("rd_dv_n3", {62'd0, C_DV, H_DV}, 64'd0);
        check("rd_c_dq_hold", {32'd0, C_DQ}, 64'd5);

        // Contention: C writes AA to 7, H reads 7
        @(negedge CLK);
        C_REQ = 1'b1; C_WE = 1'b1; C_A = 16'd7; C_DI = 32'hAA;
        H_REQ = 1'b1; H_WE = 1'b0; H_A = 16'd7;
        #1 check("ct_gnt0", {61'd0, C_GNT, H_GNT, M_WE}, 64'b101);
        @(negedge CLK);
        C_REQ = 1'b0; C_WE = 1'b0;
        #1 check("ct_gnt1", {60'd0, C_GNT, H_GNT, M_WE, 1'b0}, {60'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        check("ct_ma1", {48'd0, M_A}, 64'd7);
        idle();
        check("ct_dv_n1", {62'd0, C_DV, H_DV}, 64'd0);
        @(negedge CLK);
        check("ct_dv_n2", {62'd0, C_DV, H_DV}, 64'b01);
        check("ct_h_dq",  {32'd0, H_DQ}, 64'hAA);
        @(negedge CLK);
        check("ct_dv_n3", {62'd0, C_DV, H_DV}, 64'd0);

        // Streaming reads 0..5
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i < 6) begin
                C_REQ = 1'b1; C_WE = 1'b0; C_A = AW'(i);
            end else begin
                C_REQ = 1'b0;
            end
            if (i >= 2) begin
                check($sformatf("st_dv%0d", i - 2), {63'd0, C_DV}, 64'd1);
                check($sformatf("st_dq%0d", i - 2), {32'd0, C_DQ}, {32'd0, stream_val[i - 2]});
            end else begin
                check($sformatf("st_pre%0d", i), {63'd0, C_DV}, 64'd0);
            end
        end
        @(negedge CLK);
        check("st_dv_end", {63'd0, C_DV}, 64'd0);

        // Reset while a read is in flight
        @(negedge CLK);
        C_REQ = 1'b1; C_WE = 1'b0; C_A = 16'd3;
        #1 check("mr_gnt", {63'd0, C_GNT}, 64'd1);
        @(negedge CLK);
        C_REQ = 1'b0;
        RSTN = 1'b0;
        #1 check("mr_c_dq_rst", {32'd0, C_DQ}, 64'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("mr_dv%0d", i), {62'd0, C_DV, H_DV}, 64'd0);
        end
        check("mr_c_dq", {32'd0, C_DQ}, 64'd0);
        check("mr_h_dq", {32'd0, H_DQ}, 64'd0);

        // Continuous contention
        for (int i = 0; i < 100; i++) begin
            logic exp_h;
            @(negedge CLK);
            C_REQ = 1'b1; C_WE = 1'b0; C_A = 16'd0;
            H_REQ = 1'b1; H_WE = 1'b0; H_A = 16'd1;
`ifdef DMEM_ARB_STARVE_EN
            exp_h = ((i % 10) == 9);
`else
            exp_h = 1'b0;
`endif
            #1 check($sformatf("sv_gnt%0d", i), {62'd0, C_GNT, H_GNT}, {62'd0, ~exp_h, exp_h});
        end
        idle();
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
